// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: PC register with sequential/hold/redirect selection,
// a run-time loadable word-addressed instruction memory and the IF/ID register.
module instr_fetch_stage #(
    parameter int               XLEN       = 32,
    parameter int               IMEM_DEPTH = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter logic [XLEN-1:0]  NOP_INSN   = XLEN'(1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall,
    input  logic                          redirect,
    input  logic [XLEN-1:0]               redirect_pc,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [XLEN-1:0]               imem_wdata,
    output logic [XLEN-1:0]               pc,
    output logic [XLEN-1:0]               ir_out,
    output logic [XLEN-1:0]               pc4_out,
    output logic                          valid_out,
    output logic                          fault_out,
    output logic [XLEN-1:0]               fetch_count
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [XLEN-1:0] mem [IMEM_DEPTH];

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] count_q, count_d;

    logic [AW-1:0]   rd_idx;
    logic [XLEN-1:0] rd_data;
    logic [XLEN-1:0] pc_plus4;
    logic            in_range;

    // Memory has no reset; the read is combinational so a same-edge write is not seen
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr] <= imem_wdata;
        end
    end

    always_comb begin
        rd_idx   = pc_q[AW+1:2];
        rd_data  = mem[rd_idx];
        pc_plus4 = pc_q + XLEN'(4);
        in_range = (pc_q >> 2) < XLEN'(IMEM_DEPTH);
    end

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        count_d = count_q;
        if (redirect) begin
            // Redirect beats stall and leaves a single bubble; pc4_out keeps its value
            pc_d    = redirect_pc & ~XLEN'(3);
            ir_d    = NOP_INSN;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (!stall) begin
            pc_d  = pc_plus4;
            pc4_d = pc_plus4;
            if (in_range) begin
                ir_d    = rd_data;
                valid_d = 1'b1;
                fault_d = 1'b0;
                count_d = count_q + XLEN'(1);
            end else begin
                ir_d    = NOP_INSN;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSN;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign pc          = pc_q;
    assign ir_out      = ir_q;
    assign pc4_out     = pc4_q;
    assign valid_out   = valid_q;
    assign fault_out   = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed vector table, hand-written
// async-reset sequence, then random traffic against a behavioural model.
module tb_instr_fetch_stage;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 32;
    localparam logic [31:0] NOP   = 32'h1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect, imem_we;
    logic [31:0] redirect_pc, imem_wdata;
    logic [4:0]  imem_waddr;
    logic [31:0] pc, ir_out, pc4_out, fetch_count;
    logic        valid_out, fault_out;

    int testsRun = 0;
    int testsFailed = 0;

    // Behavioural reference state
    logic [31:0] mMem [DEPTH];
    logic [31:0] mPc, mIr, mPc4, mCount;
    logic        mValid, mFault;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] ePc, eIr, ePc4;
        logic        eValid, eFault;
        logic [31:0] eCount;
    } vec_t;

    vec_t tbl[16];

    instr_fetch_stage #(
        .XLEN(XLEN), .IMEM_DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_INSN(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .pc(pc), .ir_out(ir_out), .pc4_out(pc4_out),
        .valid_out(valid_out), .fault_out(fault_out), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [31:0] ePc, input logic [31:0] eIr,
                                input logic [31:0] ePc4, input logic eV, input logic eF,
                                input logic [31:0] eC);
        vec_t v;
        v.stall = s; v.redirect = r; v.rpc = rpc; v.we = we; v.waddr = wa; v.wdata = wd;
        v.ePc = ePc; v.eIr = eIr; v.ePc4 = ePc4; v.eValid = eV; v.eFault = eF; v.eCount = eC;
        return v;
    endfunction

    function automatic void modelReset();
        mPc = 32'h0; mIr = NOP; mPc4 = 32'h0; mValid = 1'b0; mFault = 1'b0; mCount = 32'h0;
    endfunction

    // One clock edge of the fetch stage, written from the architectural rules
    function automatic void modelStep(input logic s, input logic r, input logic [31:0] rpc,
                                      input logic we, input logic [4:0] wa,
                                      input logic [31:0] wd);
        longint unsigned nextPc;
        longint unsigned wordIdx;
        nextPc  = (longint'(mPc) + 4) % 64'h1_0000_0000;
        wordIdx = longint'(mPc) / 4;
        if (r) begin
            mPc    = (rpc / 4) * 4;
            mIr    = NOP;
            mValid = 1'b0;
            mFault = 1'b0;
        end else if (!s) begin
            if (wordIdx < DEPTH) begin
                mIr    = mMem[wordIdx];
                mValid = 1'b1;
                mFault = 1'b0;
                mCount = mCount + 1;
            end else begin
                mIr    = NOP;
                mValid = 1'b0;
                mFault = 1'b1;
            end
            mPc  = nextPc[31:0];
            mPc4 = nextPc[31:0];
        end
        if (we) mMem[wa] = wd;
    endfunction

    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd);
        stall = s; redirect = r; redirect_pc = rpc;
        imem_we = we; imem_waddr = wa; imem_wdata = wd;
        @(posedge clk);
        modelStep(s, r, rpc, we, wa, wd);
        #1;
        imem_we = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] ePc, input logic [31:0] eIr,
                               input logic [31:0] ePc4, input logic eV, input logic eF,
                               input logic [31:0] eC);
        testsRun++;
        if (pc !== ePc || ir_out !== eIr || pc4_out !== ePc4 || valid_out !== eV ||
            fault_out !== eF || fetch_count !== eC) begin
            testsFailed++;
            $display("[TB] FAIL %s: got pc=%h ir=%h pc4=%h v=%b f=%b cnt=%0d, want pc=%h ir=%h pc4=%h v=%b f=%b cnt=%0d",
                     name, pc, ir_out, pc4_out, valid_out, fault_out, fetch_count,
                     ePc, eIr, ePc4, eV, eF, eC);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;

        //           stall redir rpc           we wa     wdata     pc            ir            pc4           v  f  cnt
        tbl[0]  = mk(0, 0, 32'h0,        0, 5'd0, 32'h0,  32'h4,        32'h11,       32'h4,        1, 0, 1);
        tbl[1]  = mk(0, 0, 32'h0,        0, 5'd0, 32'h0,  32'h8,        32'h22,       32'h8,        1, 0, 2);
        tbl[2]  = mk(1, 0, 32'h0,        0, 5'd0, 32'h0,  32'h8,        32'h22,       32'h8,        1, 0, 2);
        tbl[3]  = mk(1, 0, 32'h0,        0, 5'd0, 32'h0,  32'h8,        32'h22,       32'h8,        1, 0, 2);
        tbl[4]  = mk(0, 0, 32'h0,        0, 5'd0, 32'h0,  32'hC,        32'h33,       32'hC,        1, 0, 3);
        tbl[5]  = mk(1, 1, 32'h5,        0, 5'd0, 32'h0,  32'h4,        NOP,          32'hC,        0, 0, 3);
        tbl[6]  = mk(0, 0, 32'h0,        0, 5'd0, 32'h0,  32'h8,        32'h22,       32'h8,        1, 0, 4);
        tbl[7]  = mk(0, 1, 32'h7C,       0, 5'd0, 32'h0,  32'h7C,       NOP,          32'h8,        0, 0, 4);
        tbl[8]  = mk(0, 0, 32'h0,        0, 5'd0, 32'h0,  32'h80,       32'h101F,     32'h80,       1, 0, 5);
        tbl[9]  = mk(0, 0, 32'h0,        0, 5'd0, 32'h0,  32'h84,       NOP,          32'h84,       0, 1, 5);
        tbl[10] = mk(0, 1, 32'hFFFFFFFC, 0, 5'd0, 32'h0,  32'hFFFFFFFC, NOP,          32'h84,       0, 0, 5);
        tbl[11] = mk(0, 0, 32'h0,        0, 5'd0, 32'h0,  32'h0,        NOP,          32'h0,        0, 1, 5);
        tbl[12] = mk(0, 0, 32'h0,        0, 5'd0, 32'h0,  32'h4,        32'h11,       32'h4,        1, 0, 6);
        tbl[13] = mk(0, 0, 32'h0,        1, 5'd1, 32'hAA, 32'h8,        32'h22,       32'h8,        1, 0, 7);
        tbl[14] = mk(0, 1, 32'h4,        0, 5'd0, 32'h0,  32'h4,        NOP,          32'h8,        0, 0, 7);
        tbl[15] = mk(0, 0, 32'h0,        0, 5'd0, 32'h0,  32'h8,        32'hAA,       32'h8,        1, 0, 8);

        // Load memory while held in reset; memory itself is not reset
        for (int i = 0; i < DEPTH; i++) begin
            imem_we = 1'b1; imem_waddr = 5'(i);
            imem_wdata = (i == 0) ? 32'h11 : (i == 1) ? 32'h22 : (i == 2) ? 32'h33 : 32'h1000 + 32'(i);
            @(posedge clk);
            mMem[i] = imem_wdata;
            #1;
        end
        imem_we = 1'b0;
        modelReset();
        checkOutput("reset_values", 32'h0, NOP, 32'h0, 0, 0, 0);

        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].stall, tbl[i].redirect, tbl[i].rpc,
                          tbl[i].we, tbl[i].waddr, tbl[i].wdata);
            checkOutput($sformatf("vec%0d", i), tbl[i].ePc, tbl[i].eIr, tbl[i].ePc4,
                        tbl[i].eValid, tbl[i].eFault, tbl[i].eCount);
        end

        // Asynchronous reset dropped mid-cycle during a stall
        stall = 1'b1; redirect = 1'b0;
        #3 rst_n = 1'b0;
        #1 checkOutput("async_reset_immediate", 32'h0, NOP, 32'h0, 0, 0, 0);
        redirect = 1'b1; redirect_pc = 32'h40;
        @(posedge clk); #1;
        checkOutput("reset_ignores_redirect", 32'h0, NOP, 32'h0, 0, 0, 0);
        rst_n = 1'b1;
        modelReset();
        applyStimulus(0, 0, 32'h0, 0, 5'd0, 32'h0);
        checkOutput("resume_after_reset", 32'h4, 32'h11, 32'h4, 1, 0, 1);

        for (int i = 0; i < 400; i++) begin
            logic s, r, we;
            logic [31:0] rpc, wd;
            logic [4:0] wa;
            s   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 9) == 0);
            rpc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 160)) : $urandom;
            we  = ($urandom_range(0, 2) == 0);
            wa  = 5'($urandom_range(0, DEPTH - 1));
            wd  = $urandom;
            applyStimulus(s, r, rpc, we, wa, wd);
            checkOutput($sformatf("rand%0d", i), mPc, mIr, mPc4, mValid, mFault, mCount);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
